// File: rtl/array_division_cell.sv
// Controlled add/subtract cell for a non-restoring array divider, optionally registered.
// Define ARRAY_DIV_CELL_GP_EN to add generate/propagate outputs for carry-lookahead rows.
module array_division_cell #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic in_x,
  input  logic in_y,
  input  logic in_mode,
  input  logic in_carry,
  output logic out_sum,
  output logic out_y,
  output logic out_mode,
`ifdef ARRAY_DIV_CELL_GP_EN
  output logic out_gen,
  output logic out_prop,
`endif
  output logic out_carry
);

  // Divisor bit conditionally inverted: subtract adds ~y plus the row's carry-in of 1.
  logic yx;
  logic sum_c;
  logic carry_c;
  logic gen_c;
  logic prop_c;

  assign yx      = in_y ^ in_mode;
  assign gen_c   = in_x & yx;
  assign prop_c  = in_x ^ yx;
  assign sum_c   = prop_c ^ in_carry;
  assign carry_c = gen_c | (in_carry & prop_c);

  generate
    if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          out_sum   <= 1'b0;
          out_y     <= 1'b0;
          out_mode  <= 1'b0;
          out_carry <= 1'b0;
`ifdef ARRAY_DIV_CELL_GP_EN
          out_gen   <= 1'b0;
          out_prop  <= 1'b0;
`endif
        end else begin
          out_sum   <= sum_c;
          out_y     <= in_y;
          out_mode  <= in_mode;
          out_carry <= carry_c;
`ifdef ARRAY_DIV_CELL_GP_EN
          out_gen   <= gen_c;
          out_prop  <= prop_c;
`endif
        end
      end
      logic unused_gp;
      assign unused_gp = gen_c ^ prop_c;
    end else begin : g_comb
      // clk and clr have no function in the combinational build.
      logic unused_clk_clr;
      assign unused_clk_clr = clk ^ clr;
      assign out_sum   = sum_c;
      assign out_y     = in_y;
      assign out_mode  = in_mode;
      assign out_carry = carry_c;
`ifdef ARRAY_DIV_CELL_GP_EN
      assign out_gen   = gen_c;
      assign out_prop  = prop_c;
`else
      logic unused_gp;
      assign unused_gp = gen_c ^ prop_c;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_array_division_cell.sv
// Randomized self-checking bench: combinational cell, registered cell and a 32-cell subtract/add row.
module tb_array_division_cell;

`ifdef ARRAY_DIV_CELL_GP_EN
  localparam int unsigned NB = 6;
`else
  localparam int unsigned NB = 4;
`endif
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic x = 1'b0, y = 1'b0, m = 1'b0, c = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  // Cell outputs packed as {gen, prop, mode, y, carry, sum}.
  logic cs, cy, cm, cc, rs, ry, rm, rc;
  logic cg, cp, rg, rp;
  logic [5:0] comb_v, reg_v, exp_reg;

  array_division_cell #(.REGISTERED(1'b0)) u_comb (
    .clk(clk), .clr(clr), .in_x(x), .in_y(y), .in_mode(m), .in_carry(c),
    .out_sum(cs), .out_y(cy), .out_mode(cm),
`ifdef ARRAY_DIV_CELL_GP_EN
    .out_gen(cg), .out_prop(cp),
`endif
    .out_carry(cc));

  array_division_cell #(.REGISTERED(1'b1)) u_reg (
    .clk(clk), .clr(clr), .in_x(x), .in_y(y), .in_mode(m), .in_carry(c),
    .out_sum(rs), .out_y(ry), .out_mode(rm),
`ifdef ARRAY_DIV_CELL_GP_EN
    .out_gen(rg), .out_prop(rp),
`endif
    .out_carry(rc));

`ifndef ARRAY_DIV_CELL_GP_EN
  assign cg = 1'b0; assign cp = 1'b0; assign rg = 1'b0; assign rp = 1'b0;
`endif
  assign comb_v = {cg, cp, cm, cy, cc, cs};
  assign reg_v  = {rg, rp, rm, ry, rc, rs};

  // 32-cell row: mode ripples MSB to LSB, carry ripples LSB to MSB, LSB cin = mode.
  logic [W-1:0] row_x, row_y, row_s, row_yo, row_g, row_p;
  logic         row_mode;
  logic [W:0]   row_c, row_m;
  assign row_c[0] = row_mode;
  assign row_m[W] = row_mode;

  for (genvar i = 0; i < W; i++) begin : g_row
    array_division_cell #(.REGISTERED(1'b0)) u_cell (
      .clk(clk), .clr(clr), .in_x(row_x[i]), .in_y(row_y[i]), .in_mode(row_m[i+1]),
      .in_carry(row_c[i]), .out_sum(row_s[i]), .out_y(row_yo[i]), .out_mode(row_m[i]),
`ifdef ARRAY_DIV_CELL_GP_EN
      .out_gen(row_g[i]), .out_prop(row_p[i]),
`endif
      .out_carry(row_c[i+1]));
`ifndef ARRAY_DIV_CELL_GP_EN
    assign row_g[i] = 1'b0;
    assign row_p[i] = 1'b0;
`endif
  end

  // Reference: the cell adds x, the effective divisor bit and carry-in as small integers.
  function automatic logic [5:0] model(input logic xi, yi, mi, ci);
    int b, t;
    logic [5:0] r;
    b = int'(yi ^ mi);
    t = int'(xi) + b + int'(ci);
    r[0] = (t % 2) == 1;
    r[1] = t >= 2;
    r[2] = yi;
    r[3] = mi;
    r[4] = (int'(xi) + b) == 1;
    r[5] = (int'(xi) + b) == 2;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Registered reference: one-cycle delay of the model, zeroed while clr is low.
  always @(posedge clk or negedge clr) begin
    if (!clr) exp_reg <= 6'd0;
    else      exp_reg <= model(x, y, m, c);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [5:0] e;
      e = model(x, y, m, c);
      check("comb_cycle", 64'(comb_v[NB-1:0]), 64'(e[NB-1:0]));
      check("reg_cycle", 64'(reg_v[NB-1:0]), 64'(exp_reg[NB-1:0]));
    end
  end

  task automatic set_in(input logic xi, yi, mi, ci);
    x = xi; y = yi; m = mi; c = ci;
  endtask

  task automatic row_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
    logic [W:0] exp_full;
    row_x = a; row_y = b; row_mode = md;
    #1;
    if (md) exp_full = {(a >= b), a - b};
    else    exp_full = (W+1)'(a) + (W+1)'(b);
    check("row_result", 64'(row_s), 64'(exp_full[W-1:0]));
    check("row_carry", 64'(row_c[W]), 64'(exp_full[W]));
    check("row_ypass", 64'(row_yo), 64'(b));
    check("row_mode_lsb", 64'(row_m[0]), 64'(md));
  endtask

  initial begin
    row_x = '0; row_y = '0; row_mode = 1'b0;
    #2 clr = 1'b0;
    #1;
    check("reset_reg", 64'(reg_v[NB-1:0]), 64'd0);

    // Hand-computed vectors on the combinational cell.
    set_in(1, 1, 1, 1); #1;
    check("v1_sum", 64'(cs), 64'd0); check("v1_carry", 64'(cc), 64'd1);
    check("v1_y", 64'(cy), 64'd1);   check("v1_mode", 64'(cm), 64'd1);
    set_in(0, 1, 1, 0); #1;
    check("v2_sum", 64'(cs), 64'd0); check("v2_carry", 64'(cc), 64'd0);
    set_in(0, 1, 0, 1); #1;
    check("v3_sum", 64'(cs), 64'd0); check("v3_carry", 64'(cc), 64'd1);
    set_in(1, 0, 0, 0); #1;
    check("v4_sum", 64'(cs), 64'd1); check("v4_carry", 64'(cc), 64'd0);

    // Exhaustive 16 combinations.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [5:0] e;
      v = 4'(i);
      set_in(v[3], v[2], v[1], v[0]); #1;
      e = model(v[3], v[2], v[1], v[0]);
      check("exhaustive", 64'(comb_v[NB-1:0]), 64'(e[NB-1:0]));
    end

    // Row literal cases, then random rows.
    row_check(32'd12, 32'd7, 1'b1);
    check("row_12m7", 64'(row_s), 64'd5);
    row_check(32'd5, 32'd7, 1'b1);
    check("row_5m7", 64'(row_s), 64'hFFFF_FFFE);
    for (int i = 0; i < 40; i++) row_check($urandom, $urandom, 1'($urandom_range(0, 1)));
    row_check(32'hFFFF_FFFF, 32'd1, 1'b0);
    row_check(32'd9, 32'd9, 1'b1);

    // Release clr; first edge loads current inputs.
    @(posedge clk); #1;
    set_in(1, 0, 1, 1);
    clr = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    check("first_load", 64'(reg_v[NB-1:0]), 64'(model(1, 0, 1, 1) & 6'((1 << NB) - 1)));

    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        #2 clr = 1'b0;
        #1 check("async_clr", 64'(reg_v[NB-1:0]), 64'd0);
        @(posedge clk); #1 clr = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  logic unused_row;
  assign unused_row = ^{row_g, row_p};

endmodule
